jelly_bean_taster: RTL and testbench

- Slave-side consumer of jelly-bean transactions; sits directly downstream of the master driver on the jelly_bean bus.
- Samples flavor/color/sugar_free/sour/command on each rising clock edge and answers on taste one cycle later.
- Keeps a per-flavor verdict table, running yummy/yucky tallies, and a fatigue state machine that makes it rest after a run of bad beans.

---
 rtl/jelly_bean_taster.sv | 113 +++++++++++
 tb/tb_jelly_bean_taster.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/jelly_bean_taster.sv
// Jelly-bean bus slave: registered taste verdicts, per-flavor table, tallies, fatigue REST.
// Latency: taste answers one cycle after the command is sampled; commands are dropped while busy.
module jelly_bean_taster #(
  parameter int FATIGUE_LIMIT = 3,
  parameter int REST_CYCLES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       flavor,
  input  logic [1:0]       color,
  input  logic             sugar_free,
  input  logic             sour,
  input  logic [1:0]       command,
  output logic [1:0]       taste,
  output logic             busy,
  output logic [CNT_W-1:0] yummy_count,
  output logic [CNT_W-1:0] yucky_count
);

  localparam logic [1:0] T_UNKNOWN = 2'd0;
  localparam logic [1:0] T_YUMMY   = 2'd1;
  localparam logic [1:0] T_YUCKY   = 2'd2;
  localparam logic [1:0] C_READ    = 2'd1;
  localparam logic [1:0] C_WRITE   = 2'd2;
  localparam logic [2:0] F_NONE    = 3'd0;
  localparam logic [2:0] F_CHOC    = 3'd4;
  localparam logic [3:0] FAT_LAST  = 4'(FATIGUE_LIMIT - 1);
  localparam logic [7:0] REST_LOAD = 8'(REST_CYCLES);

  typedef enum logic {S_TASTE, S_REST} state_t;

  state_t           state_q, state_d;
  logic [7:0]       rest_cnt_q;
  logic [3:0]       consec_q;
  logic [1:0]       taste_q;
  logic [CNT_W-1:0] yummy_q, yucky_q;
  logic [7:0]       tbl_vld;
  logic [7:0][1:0]  tbl_val;
  logic [1:0]       verdict;
  logic             do_write, do_read, fatigue_hit;

  // Sugar-free beans taste the same as regular ones.
  logic unused_sugar_free;
  assign unused_sugar_free = sugar_free;

  always_comb begin
    verdict = T_YUMMY;
    if ((flavor == F_CHOC && sour) || flavor == F_NONE || flavor >= 3'd5 || color == 2'd3)
      verdict = T_YUCKY;
  end

  assign do_write    = (state_q == S_TASTE) && (command == C_WRITE);
  assign do_read     = (state_q == S_TASTE) && (command == C_READ);
  assign fatigue_hit = do_write && (verdict == T_YUCKY) && (consec_q == FAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_TASTE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TASTE: if (fatigue_hit) state_d = S_REST;
      S_REST:  if (rest_cnt_q == 8'd1) state_d = S_TASTE;
      default: state_d = S_TASTE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_REST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taste_q    <= T_UNKNOWN;
      rest_cnt_q <= '0;
      consec_q   <= '0;
      yummy_q    <= '0;
      yucky_q    <= '0;
      tbl_vld    <= '0;
      tbl_val    <= '0;
    end else begin
      taste_q <= T_UNKNOWN;
      if (do_write) begin
        taste_q         <= verdict;
        tbl_vld[flavor] <= 1'b1;
        tbl_val[flavor] <= verdict;
        if (verdict == T_YUMMY) begin
          consec_q <= '0;
          if (yummy_q != '1) yummy_q <= yummy_q + 1'b1;
        end else begin
          consec_q <= consec_q + 1'b1;
          if (yucky_q != '1) yucky_q <= yucky_q + 1'b1;
        end
      end else if (do_read) begin
        taste_q <= tbl_vld[flavor] ? tbl_val[flavor] : T_UNKNOWN;
      end
      if (fatigue_hit) rest_cnt_q <= REST_LOAD;
      // Leaving REST wipes the bad-bean run so fatigue starts from scratch.
      if (state_q == S_REST) begin
        rest_cnt_q <= rest_cnt_q - 1'b1;
        if (rest_cnt_q == 8'd1) consec_q <= '0;
      end
    end
  end

  assign taste       = taste_q;
  assign yummy_count = yummy_q;
  assign yucky_count = yucky_q;

endmodule

// File: tb/tb_jelly_bean_taster.sv
// Directed bench for jelly_bean_taster (FATIGUE_LIMIT=3, REST_CYCLES=4, CNT_W=2).
module tb_jelly_bean_taster;

  localparam int CNT_W = 2;
  localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;
  localparam int UNK = 0, YUM = 1, YUK = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       flavor;
  logic [1:0]       color;
  logic             sugar_free;
  logic             sour;
  logic [1:0]       command;
  logic [1:0]       taste;
  logic             busy;
  logic [CNT_W-1:0] yummy_count;
  logic [CNT_W-1:0] yucky_count;

  int n_cmp = 0;
  int n_bad = 0;

  jelly_bean_taster #(.FATIGUE_LIMIT(3), .REST_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flavor(flavor), .color(color),
    .sugar_free(sugar_free), .sour(sour), .command(command),
    .taste(taste), .busy(busy), .yummy_count(yummy_count), .yucky_count(yucky_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one command, let it be sampled, then settle past the edge.
  task automatic cyc(input logic [2:0] f, input logic [1:0] c, input logic sf,
                     input logic s, input logic [1:0] cmd);
    flavor = f; color = c; sugar_free = sf; sour = s; command = cmd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(3'd0, 2'd0, 1'b0, 1'b0, NOP);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flavor = '0; color = '0; sugar_free = 1'b0; sour = 1'b0; command = NOP;
    do_reset();
    chk("rst_taste", taste, UNK);
    chk("rst_busy", busy, 0);
    chk("rst_yummy", yummy_count, 0);
    chk("rst_yucky", yucky_count, 0);

    cyc(3'd1, 2'd0, 1'b0, 1'b0, RD);
    chk("read_empty", taste, UNK);

    cyc(3'd1, 2'd0, 1'b0, 1'b0, WR);
    chk("wr_apple", taste, YUM);
    chk("wr_apple_yummy", yummy_count, 1);
    cyc(3'd1, 2'd0, 1'b0, 1'b0, RD);
    chk("rd_apple", taste, YUM);
    cyc(3'd0, 2'd0, 1'b0, 1'b0, NOP);
    chk("nop_pulse", taste, UNK);
    chk("nop_yummy", yummy_count, 1);
    chk("nop_yucky", yucky_count, 0);
    cyc(3'd1, 2'd0, 1'b0, 1'b0, 2'd3);
    chk("cmd3_taste", taste, UNK);
    chk("cmd3_yummy", yummy_count, 1);

    cyc(3'd4, 2'd0, 1'b0, 1'b1, WR);
    chk("choc_sour", taste, YUK);
    cyc(3'd2, 2'd1, 1'b0, 1'b0, WR);
    chk("blue_green", taste, YUM);
    cyc(3'd4, 2'd0, 1'b0, 1'b1, WR);
    chk("choc_sour2", taste, YUK);
    chk("run_broken_busy", busy, 0);
    chk("run_broken_yucky", yucky_count, 2);
    chk("run_broken_yummy", yummy_count, 2);
    cyc(3'd3, 2'd2, 1'b1, 1'b0, WR);
    chk("sugar_free_gum", taste, YUM);
    chk("yummy_3", yummy_count, 3);

    // Fatigue: three bad beans in a row, then REST for four cycles.
    do_reset();
    cyc(3'd0, 2'd0, 1'b0, 1'b0, WR);
    chk("fat_noflavor", taste, YUK);
    cyc(3'd5, 2'd0, 1'b0, 1'b0, WR);
    chk("fat_flavor5", taste, YUK);
    chk("fat_busy_early", busy, 0);
    cyc(3'd2, 2'd3, 1'b0, 1'b0, WR);
    chk("fat_color3", taste, YUK);
    chk("fat_busy_enter", busy, 1);
    chk("fat_yucky", yucky_count, 3);
    cyc(3'd1, 2'd0, 1'b0, 1'b0, WR);
    chk("rest_wr_taste", taste, UNK);
    chk("rest_busy1", busy, 1);
    cyc(3'd0, 2'd0, 1'b0, 1'b0, NOP);
    chk("rest_busy2", busy, 1);
    cyc(3'd0, 2'd0, 1'b0, 1'b0, NOP);
    chk("rest_busy3", busy, 1);
    cyc(3'd0, 2'd0, 1'b0, 1'b0, NOP);
    chk("rest_done_busy", busy, 0);
    chk("rest_yummy", yummy_count, 0);
    cyc(3'd1, 2'd0, 1'b0, 1'b0, RD);
    chk("rest_apple_invalid", taste, UNK);
    cyc(3'd1, 2'd0, 1'b0, 1'b0, WR);
    chk("post_rest_wr", taste, YUM);
    chk("post_rest_yummy", yummy_count, 1);
    cyc(3'd4, 2'd0, 1'b0, 1'b1, WR);
    chk("post_rest_yuck", taste, YUK);
    chk("post_rest_no_refatigue", busy, 0);

    // Tally saturation at 2^CNT_W-1.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cyc(3'd1, 2'd0, 1'b0, 1'b0, WR);
      chk($sformatf("sat_yummy_%0d", i), yummy_count, (i > 3) ? 3 : i);
    end

    // Reset in the middle of REST.
    do_reset();
    cyc(3'd4, 2'd0, 1'b0, 1'b1, WR);
    cyc(3'd6, 2'd0, 1'b0, 1'b0, WR);
    cyc(3'd2, 2'd3, 1'b0, 1'b0, WR);
    chk("mid_busy_enter", busy, 1);
    cyc(3'd0, 2'd0, 1'b0, 1'b0, NOP);
    chk("mid_busy_rest1", busy, 1);
    do_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_yucky", yucky_count, 0);
    chk("mid_rst_yummy", yummy_count, 0);
    cyc(3'd4, 2'd0, 1'b0, 1'b0, RD);
    chk("mid_rst_read_choc", taste, UNK);
    cyc(3'd2, 2'd0, 1'b0, 1'b0, WR);
    chk("mid_rst_write_ok", taste, YUM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
